// File: rtl/note_player_if.sv
// ---------------------------------------------------------------------------
// note_player_if
// Bundles the note player's control, note RAM, and codec sample signals.
//   slave  : the note player itself
//   master : whatever drives it (top-level FSM, tempo divider, RAM, codec)
// Signals:
//   start, stop, beat  1-cycle control pulses into the player
//   last_addr          final note RAM address to play (inclusive)
//   mem_addr / mem_q   note RAM read address / read data (2-edge latency)
//   audio_ready        codec sample request
//   sample             signed audio sample
//   sample_write       1-cycle strobe marking sample valid
//   cur_note           note word currently being played
//   playing, done      status (busy, end-of-program pulse)
// ---------------------------------------------------------------------------
interface note_player_if #(
    parameter int ADDR_W   = 6,
    parameter int SAMPLE_W = 16
);
    logic                start;
    logic                stop;
    logic                beat;
    logic [ADDR_W-1:0]   last_addr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_q;
    logic                audio_ready;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_write;
    logic [31:0]         cur_note;
    logic                playing;
    logic                done;

    modport slave (
        input  start, stop, beat, last_addr, mem_q, audio_ready,
        output mem_addr, sample, sample_write, cur_note, playing, done
    );

    modport master (
        output start, stop, beat, last_addr, mem_q, audio_ready,
        input  mem_addr, sample, sample_write, cur_note, playing, done
    );
endinterface

// File: rtl/note_player.sv
// ---------------------------------------------------------------------------
// note_player
// Walks the note RAM one slot per tempo beat, decodes each string/fret word to
// a semitone, and generates a square-wave sample stream for the audio codec.
// Ports:
//   clk     in  system clock (50 MHz)
//   resetn  in  synchronous active-low reset
//   bus     note_player_if.slave: start/stop/beat/last_addr in, note RAM
//           address out / data in, codec audio_ready in, sample and
//           sample_write out, cur_note/playing/done status out
// ---------------------------------------------------------------------------
module note_player #(
    parameter int          ADDR_W   = 6,
    parameter int          SAMPLE_W = 16,
    parameter logic [15:0] AMPL     = 16'd8000
) (
    input  logic          clk,
    input  logic          resetn,
    note_player_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH1,
        S_FETCH2,
        S_LATCH,
        S_PLAY,
        S_DONE
    } state_t;

    localparam logic [SAMPLE_W-1:0] AMPL_POS = SAMPLE_W'(AMPL);
    localparam logic [SAMPLE_W-1:0] AMPL_NEG = {SAMPLE_W{1'b0}} - AMPL_POS;

    // Open-string semitone offsets from E2: E2 A2 D3 G3 B3 E4
    localparam int STRING_BASE [6] = '{0, 5, 10, 15, 19, 24};

    // Half period in clk cycles for each semitone above E2 (82.4069 Hz, 50 MHz clk)
    function automatic logic [18:0] half_period_of(input logic [4:0] n);
        case (n)
            5'd0:    return 19'd303373;
            5'd1:    return 19'd286346;
            5'd2:    return 19'd270274;
            5'd3:    return 19'd255105;
            5'd4:    return 19'd240787;
            5'd5:    return 19'd227273;
            5'd6:    return 19'd214517;
            5'd7:    return 19'd202477;
            5'd8:    return 19'd191113;
            5'd9:    return 19'd180386;
            5'd10:   return 19'd170262;
            5'd11:   return 19'd160706;
            5'd12:   return 19'd151686;
            5'd13:   return 19'd143173;
            5'd14:   return 19'd135137;
            5'd15:   return 19'd127552;
            5'd16:   return 19'd120394;
            5'd17:   return 19'd113636;
            5'd18:   return 19'd107258;
            5'd19:   return 19'd101238;
            5'd20:   return 19'd95556;
            5'd21:   return 19'd90193;
            5'd22:   return 19'd85131;
            5'd23:   return 19'd80353;
            5'd24:   return 19'd75843;
            5'd25:   return 19'd71586;
            5'd26:   return 19'd67569;
            5'd27:   return 19'd63776;
            default: return 19'd60197;   // n=28; 29..31 cannot be produced
        endcase
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_cur_note;
    logic                r_rest;
    logic [18:0]         r_half;
    logic [18:0]         r_phase;
    logic                r_pol;        // 0 = positive half, 1 = negative half
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_sample_write;

    logic [4:0]          w_bit_semi [30];
    logic [4:0]          w_semi;
    logic                w_playing;
    logic                w_done;
    logic                w_abort;
    logic [SAMPLE_W-1:0] w_level;
    logic                w_unused_bits;

    // Bits 31:30 of the note word carry no string/fret information
    assign w_unused_bits = ^bus.mem_q[31:30];

    // Semitone represented by each note-word bit: string k%6, fret k/6
    for (genvar gi = 0; gi < 30; gi++) begin : g_bit_semi
        assign w_bit_semi[gi] = 5'(STRING_BASE[gi % 6] + gi / 6);
    end

    // Lowest set bit wins when several strings are pressed
    always_comb begin
        w_semi = '0;
        for (int k = 29; k >= 0; k--) begin
            if (bus.mem_q[k]) begin
                w_semi = w_bit_semi[k];
            end
        end
    end

    // Next state, status and audio level
    always_comb begin
        w_state_next = r_state;
        w_playing    = (r_state != S_IDLE);
        w_done       = (r_state == S_DONE);
        w_abort      = (r_state != S_IDLE) && bus.stop;
        w_level      = '0;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = S_FETCH1;
            S_FETCH1: w_state_next = S_FETCH2;
            S_FETCH2: w_state_next = S_LATCH;
            S_LATCH:  w_state_next = S_PLAY;
            S_PLAY: begin
                if (!r_rest) w_level = r_pol ? AMPL_NEG : AMPL_POS;
                if (bus.beat) begin
                    w_state_next = (r_mem_addr == bus.last_addr) ? S_DONE : S_FETCH1;
                end
            end
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        // stop overrides everything, including a coincident beat
        if (w_abort) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_addr     <= '0;
            r_cur_note     <= '0;
            r_rest         <= 1'b1;
            r_half         <= '0;
            r_phase        <= '0;
            r_pol          <= 1'b0;
            r_sample       <= '0;
            r_sample_write <= 1'b0;
        end else begin
            // Codec handshake: one write per request, one cycle later
            r_sample_write <= bus.audio_ready && w_playing;
            if (bus.audio_ready && w_playing) r_sample <= w_level;

            if (r_state == S_PLAY && w_state_next == S_FETCH1) begin
                r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end else if (w_state_next == S_IDLE || (r_state == S_IDLE && bus.start)) begin
                r_mem_addr <= '0;
            end

            if (r_state == S_LATCH) begin
                r_cur_note <= bus.mem_q;
                r_rest     <= ~|bus.mem_q[29:0];
                r_half     <= half_period_of(w_semi);
                r_phase    <= '0;
                r_pol      <= 1'b0;
            end else if (r_state == S_PLAY && !r_rest) begin
                if (r_phase == r_half - 19'd1) begin
                    r_phase <= '0;
                    r_pol   <= ~r_pol;
                end else begin
                    r_phase <= r_phase + 19'd1;
                end
            end

            if (w_abort) r_sample <= '0;
        end
    end

    assign bus.mem_addr     = r_mem_addr;
    assign bus.cur_note     = r_cur_note;
    assign bus.sample       = r_sample;
    assign bus.sample_write = r_sample_write;
    assign bus.playing      = w_playing;
    assign bus.done         = w_done;
endmodule

// File: tb/tb_note_player.sv
// ---------------------------------------------------------------------------
// tb_note_player
// Drives note_player through its interface with directed and randomized note
// programs. A small RAM model with 2-edge read latency feeds mem_q; expected
// values come from a note-level model (lowest pressed string/fret -> semitone,
// pitch from the equal-temperament formula).
// ---------------------------------------------------------------------------
module tb_note_player;
    localparam int          ADDR_W   = 6;
    localparam int          SAMPLE_W = 16;
    localparam logic [15:0] AMPL     = 16'd8000;
    localparam logic [15:0] S_NEG    = 16'hE0C0;   // -8000 in two's complement

    logic clk = 1'b0;
    logic resetn;
    always #10 clk = ~clk;

    note_player_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) bus ();

    note_player #(
        .ADDR_W  (ADDR_W),
        .SAMPLE_W(SAMPLE_W),
        .AMPL    (AMPL)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    // Note RAM: address registered, then data registered (2-edge latency)
    logic [31:0] ram [64];
    logic [31:0] q1;
    always @(posedge clk) begin
        q1        <= ram[bus.mem_addr];
        bus.mem_q <= q1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: semitone of the lowest pressed string/fret, -1 for a rest
    function automatic int ref_note(input logic [31:0] w);
        int base [6] = '{0, 5, 10, 15, 19, 24};
        for (int k = 0; k < 30; k++) begin
            if (w[k]) return base[k % 6] + k / 6;
        end
        return -1;
    endfunction

    function automatic int ref_half(input int n);
        real f;
        f = 82.4069 * (2.0 ** (n / 12.0));
        return $rtoi(25000000.0 / f + 0.5);
    endfunction

    // First half-period level of a slot: +AMPL for a note, 0 for a rest
    function automatic logic [31:0] exp_level(input logic [31:0] w);
        return (ref_note(w) < 0) ? 32'd0 : 32'(AMPL);
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'd1 << $urandom_range(0, 29);
            2:       return $urandom();
            default: return 32'hC000_0000 | (32'd1 << $urandom_range(0, 29));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Plays a program already started (DUT in FETCH1 at slot 0) to its end
    task automatic run_program(input int last);
        for (int i = 0; i <= last; i++) begin
            if ($urandom_range(0, 1) == 1) bus.beat = 1'b1;   // lands in FETCH1, ignored
            tick();
            bus.beat = 1'b0;
            tick();
            tick();
            chk("slot_addr", 32'(bus.mem_addr), 32'(i));
            chk("slot_note", bus.cur_note, ram[i]);
            bus.audio_ready = 1'b1;
            tick();
            bus.audio_ready = 1'b0;
            chk("slot_write", 32'(bus.sample_write), 32'd1);
            chk("slot_level", 32'(bus.sample), exp_level(ram[i]));
            repeat ($urandom_range(0, 20)) tick();
            bus.beat = 1'b1;
            tick();
            bus.beat = 1'b0;
            if (i == last) begin
                chk("slot_done", 32'(bus.done), 32'd1);
                tick();
                chk("slot_idle", 32'(bus.playing), 32'd0);
                chk("slot_addr0", 32'(bus.mem_addr), 32'd0);
            end else begin
                chk("slot_next", 32'(bus.mem_addr), 32'(i + 1));
                chk("slot_nodone", 32'(bus.done), 32'd0);
            end
        end
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int cnt;
        int writes;
        int dones;
        int last;

        for (int a = 0; a < 64; a++) ram[a] = 32'd0;
        bus.start       = 1'b1;
        bus.stop        = 1'b0;
        bus.beat        = 1'b0;
        bus.last_addr   = '0;
        bus.audio_ready = 1'b1;
        resetn          = 1'b0;

        // Reset held with start asserted
        repeat (3) tick();
        chk("rst_playing", 32'(bus.playing), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_sample", 32'(bus.sample), 32'd0);
        chk("rst_write", 32'(bus.sample_write), 32'd0);
        bus.start = 1'b0;
        resetn    = 1'b1;
        tick();
        tick();
        chk("idle_write", 32'(bus.sample_write), 32'd0);

        // Single A2 note, last_addr = 0
        ram[0] = 32'h0000_0002;
        do_start();
        tick();
        tick();
        tick();
        chk("a2_note", bus.cur_note, 32'h0000_0002);
        tick();
        chk("a2_level", 32'(bus.sample), exp_level(32'h0000_0002));
        chk("a2_write", 32'(bus.sample_write), 32'd1);
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            bus.start = (c == 50);    // must be ignored while playing
            tick();
            if (bus.sample !== AMPL || bus.sample_write !== 1'b1 ||
                bus.mem_addr !== 6'd0 || bus.playing !== 1'b1) bad++;
        end
        bus.start = 1'b0;
        chk("a2_hold_bad", 32'(bad), 32'd0);
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        chk("a2_done", 32'(bus.done), 32'd1);
        tick();
        chk("a2_done_once", 32'(bus.done), 32'd0);
        chk("a2_idle", 32'(bus.playing), 32'd0);
        tick();
        chk("a2_idle_write", 32'(bus.sample_write), 32'd0);

        // Multi-note: note, rest, string5 fret4 (highest pitch)
        ram[0] = 32'h0000_0001;
        ram[1] = 32'h0000_0000;
        ram[2] = 32'h2000_0000;
        bus.last_addr = 6'd2;
        do_start();
        tick();
        tick();
        tick();
        chk("mn_addr0", 32'(bus.mem_addr), 32'd0);
        tick();
        chk("mn_level0", 32'(bus.sample), exp_level(ram[0]));
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        chk("mn_addr1", 32'(bus.mem_addr), 32'd1);
        repeat (5) tick();
        chk("mn_rest", 32'(bus.sample), 32'd0);
        chk("mn_rest_write", 32'(bus.sample_write), 32'd1);
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        chk("mn_addr2", 32'(bus.mem_addr), 32'd2);
        cnt = 0;
        for (int c = 0; c < 70000; c++) begin
            tick();
            if (bus.sample === AMPL) cnt++;
            else if (cnt > 0) break;
        end
        chk("mn_half_period", 32'(cnt), 32'(ref_half(ref_note(ram[2]))));
        chk("mn_neg", 32'(bus.sample), 32'(S_NEG));
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        chk("mn_done", 32'(bus.done), 32'd1);
        tick();
        chk("mn_idle", 32'(bus.playing), 32'd0);

        // Multi-bit word with bits 31:30 set; then 31:30 alone is a rest
        ram[0] = 32'hC000_0041;
        bus.last_addr = 6'd0;
        do_start();
        repeat (3) tick();
        chk("mb_note", bus.cur_note, 32'hC000_0041);
        tick();
        chk("mb_level", 32'(bus.sample), exp_level(ram[0]));
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        tick();
        ram[0] = 32'hC000_0000;
        do_start();
        repeat (4) tick();
        chk("hi_bits_rest", 32'(bus.sample), exp_level(ram[0]));
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        tick();

        // Abort with stop and beat together during slot 1
        for (int a = 0; a < 4; a++) ram[a] = 32'd1 << $urandom_range(0, 29);
        bus.last_addr = 6'd3;
        do_start();
        repeat (3) tick();
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        repeat (3) tick();
        tick();
        chk("ab_level", 32'(bus.sample), 32'(AMPL));
        bus.beat = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.beat = 1'b0;
        bus.stop = 1'b0;
        chk("ab_idle", 32'(bus.playing), 32'd0);
        chk("ab_addr", 32'(bus.mem_addr), 32'd0);
        chk("ab_done", 32'(bus.done), 32'd0);
        chk("ab_sample", 32'(bus.sample), 32'd0);
        writes = 0;
        dones  = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.sample_write === 1'b1) writes++;
            if (bus.done === 1'b1) dones++;
        end
        chk("ab_writes_after", 32'(writes), 32'd0);
        chk("ab_dones_after", 32'(dones), 32'd0);
        bus.audio_ready = 1'b0;

        // Handshake: sparse codec requests, idle first, then playing
        writes = 0;
        for (int c = 0; c < 2100; c++) begin
            bus.audio_ready = (c % 1042 == 0);
            tick();
            if (bus.sample_write === 1'b1) writes++;
        end
        bus.audio_ready = 1'b0;
        chk("hs_idle_writes", 32'(writes), 32'd0);
        ram[0] = 32'h0000_0008;
        bus.last_addr = 6'd0;
        do_start();
        repeat (3) tick();
        writes = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 1040; c++) begin
                bus.start = (r == 2 && c == 100);   // ignored while playing
                tick();
                if (bus.sample_write === 1'b1) writes++;
            end
            bus.start       = 1'b0;
            bus.audio_ready = 1'b1;
            tick();
            bus.audio_ready = 1'b0;
            chk("hs_write", 32'(bus.sample_write), 32'd1);
            chk("hs_level", 32'(bus.sample), 32'(AMPL));
            tick();
            chk("hs_write_once", 32'(bus.sample_write), 32'd0);
        end
        chk("hs_stray_writes", 32'(writes), 32'd0);

        // Reset in the middle of playback
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mr_playing", 32'(bus.playing), 32'd0);
        chk("mr_addr", 32'(bus.mem_addr), 32'd0);
        chk("mr_note", bus.cur_note, 32'd0);
        chk("mr_sample", 32'(bus.sample), 32'd0);
        tick();

        // Randomized programs
        for (int t = 0; t < 6; t++) begin
            last = $urandom_range(0, 7);
            for (int a = 0; a <= last; a++) ram[a] = rand_word();
            bus.last_addr = ADDR_W'(last);
            do_start();
            run_program(last);
            repeat ($urandom_range(1, 5)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
